// File: rtl/logit_argmax_sequencer_pkg.sv
// Shared types and constants for the logit -> argmax sequencer slice.
package logit_argmax_sequencer_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned DATA_W      = 54;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned TIMEOUT     = 64;
  localparam int unsigned CNT_W       = 16;

  localparam int unsigned BEAT_W = $clog2(NUM_CLASSES + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);
  localparam int unsigned ST_W   = 3;

  typedef logic signed [DATA_W-1:0] logit_t;
  typedef logit_t [NUM_CLASSES-1:0] logit_vec_t;

  typedef logic [ST_W-1:0] seq_state_t;

  localparam seq_state_t ST_COLLECT  = 3'd0;
  localparam seq_state_t ST_DRAIN    = 3'd1;
  localparam seq_state_t ST_FIRE     = 3'd2;
  localparam seq_state_t ST_WAIT     = 3'd3;
  localparam seq_state_t ST_HOLD     = 3'd4;
  localparam seq_state_t ST_ERR_HOLD = 3'd5;

  localparam logic [IDX_W-1:0] ERR_CLASS = 4'hF;

  // Result payload presented to the host.
  typedef struct packed {
    logic             error;
    logic [IDX_W-1:0] cls;
  } res_t;

  localparam res_t RES_ERR = '{error: 1'b1, cls: ERR_CLASS};

endpackage

// File: rtl/logit_argmax_sequencer_if.sv
// Logit stream, argmax handshake and host result bus of the sequencer.
interface logit_argmax_sequencer_if;
  import logit_argmax_sequencer_pkg::*;

  logic             logit_valid;
  logic             logit_ready;
  logit_t           logit_data;
  logic             logit_last;

  logic             am_valid_in;
  logit_vec_t       am_data;
  logic [IDX_W-1:0] am_max_index;
  logic             am_done;

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_class;
  logic             res_error;

  logic             busy;
  logic [CNT_W-1:0] image_count;

  // Environment side: drives logits, hosts the argmax unit, consumes results.
  modport master (
    output logit_valid, logit_data, logit_last, am_max_index, am_done, res_ready,
    input  logit_ready, am_valid_in, am_data, res_valid, res_class, res_error,
           busy, image_count
  );

  // Sequencer side.
  modport slave (
    input  logit_valid, logit_data, logit_last, am_max_index, am_done, res_ready,
    output logit_ready, am_valid_in, am_data, res_valid, res_class, res_error,
           busy, image_count
  );

endinterface

// File: rtl/logit_argmax_sequencer_buffer.sv
// One image's worth of logits: indexed write, parallel read, synchronous clear.
module logit_argmax_sequencer_buffer
  import logit_argmax_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_idx,
  input  logit_t            wr_data,
  output logit_vec_t        rd_data
);

  logit_vec_t mem_q;
  logit_vec_t mem_d;

  // Write wins over clear so the first beat of a frame lands in a clean buffer.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
        if (wr_idx == BEAT_W'(i)) begin
          mem_d[i] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/logit_argmax_sequencer.sv
// Buffers one image of class logits, fires the argmax unit, returns the winner
// (or an error result) to the host and counts accepted results.
module logit_argmax_sequencer
  import logit_argmax_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  logit_argmax_sequencer_if.slave  bus
);

  seq_state_t        state_q, state_d;
  logic [BEAT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  res_t              res_q, res_d;
  logic [CNT_W-1:0]  img_q, img_d;
  logic              logit_ready_q, logit_ready_d;
  logic              am_valid_q, am_valid_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;

  logic              beat_c;
  logic              buf_wr_c;
  logic              buf_clr_c;
  logit_vec_t        buf_rd;

  assign beat_c    = bus.logit_valid && logit_ready_q;
  assign buf_wr_c  = (state_q == ST_COLLECT) && beat_c;
  assign buf_clr_c = buf_wr_c && (count_q == '0);

  logit_argmax_sequencer_buffer u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr_c),
    .wr_en   (buf_wr_c),
    .wr_idx  (count_q),
    .wr_data (bus.logit_data),
    .rd_data (buf_rd)
  );

  // Next state; registered outputs are decoded from the next state so they
  // line up with the state register.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmr_d   = tmr_q;
    res_d   = res_q;
    img_d   = img_q;

    case (state_q)
      ST_COLLECT: begin
        if (beat_c) begin
          count_d = count_q + 1'b1;
          if (count_q == BEAT_W'(NUM_CLASSES - 1)) begin
            state_d = bus.logit_last ? ST_FIRE : ST_DRAIN;
          end else if (bus.logit_last) begin
            state_d = ST_ERR_HOLD;
            res_d   = RES_ERR;
          end
        end
      end
      ST_DRAIN: begin
        if (beat_c && bus.logit_last) begin
          state_d = ST_ERR_HOLD;
          res_d   = RES_ERR;
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT;
        tmr_d   = '0;
      end
      ST_WAIT: begin
        if (bus.am_done) begin
          state_d = ST_HOLD;
          res_d   = '{error: 1'b0, cls: bus.am_max_index};
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR_HOLD;
          res_d   = RES_ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HOLD, ST_ERR_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = ST_COLLECT;
          count_d = '0;
          img_d   = img_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        count_d = '0;
      end
    endcase

    logit_ready_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
    am_valid_d    = (state_d == ST_FIRE);
    res_valid_d   = (state_d == ST_HOLD) || (state_d == ST_ERR_HOLD);
    busy_d        = !((state_d == ST_COLLECT) && (count_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_COLLECT;
      count_q       <= '0;
      tmr_q         <= '0;
      res_q         <= '0;
      img_q         <= '0;
      logit_ready_q <= 1'b1;
      am_valid_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tmr_q         <= tmr_d;
      res_q         <= res_d;
      img_q         <= img_d;
      logit_ready_q <= logit_ready_d;
      am_valid_q    <= am_valid_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.logit_ready = logit_ready_q;
  assign bus.am_valid_in = am_valid_q;
  assign bus.am_data     = buf_rd;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_class   = res_q.cls;
  assign bus.res_error   = res_q.error;
  assign bus.busy        = busy_q;
  assign bus.image_count = img_q;

endmodule

// File: tb/tb_logit_argmax_sequencer.sv
// Directed bench: sequencer paired with a behavioural argmax unit (or a stub
// that never answers) and a scoreboard of expected host results.
module tb_logit_argmax_sequencer;
  import logit_argmax_sequencer_pkg::*;

  localparam int unsigned AM_LAT = 2;

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] cls;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logit_argmax_sequencer_if bus ();

  logit_argmax_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fire_cnt = 0;
  int fire_cyc = 0;
  int last_beat_cyc = 0;
  int exp_img = 0;

  logic             stub_mode = 1'b0;
  logic             model_done = 1'b0;
  logic             spur_done = 1'b0;
  logic [IDX_W-1:0] model_idx = '0;
  logic             am_pending = 1'b0;
  int               am_delay = 0;
  logic [IDX_W-1:0] am_idx = '0;

  exp_t   sb_q[$];
  logit_t fb[16];
  logit_t norm[10] = '{10, 20, 5, 100, 50, 12, 80, 45, 1, 99};

  assign bus.am_done      = model_done | spur_done;
  assign bus.am_max_index = model_idx;

  always @(posedge clk) cyc++;

  function automatic logic [IDX_W-1:0] argmax_of(input logit_vec_t v);
    int best = 0;
    for (int i = 1; i < int'(NUM_CLASSES); i++) begin
      if (v[i] > v[best]) best = i;
    end
    return IDX_W'(best);
  endfunction

  // Argmax unit model: answers AM_LAT cycles after the start pulse unless stubbed.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      am_pending = 1'b0;
    end else if (am_pending) begin
      if (am_delay == 0) begin
        model_done = !stub_mode;
        model_idx  = am_idx;
        am_pending = 1'b0;
      end else begin
        am_delay--;
      end
    end
    if (bus.am_valid_in === 1'b1) begin
      fire_cnt++;
      fire_cyc   = cyc;
      am_pending = 1'b1;
      am_delay   = AM_LAT;
      am_idx     = argmax_of(bus.am_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_logit_ready", bus.logit_ready, 1);
    check("rst_am_valid_in", bus.am_valid_in, 0);
    check("rst_am_data_zero", bus.am_data === '0, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_class", bus.res_class, 0);
    check("rst_res_error", bus.res_error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_image_count", bus.image_count, 0);
  endtask

  task automatic send_beat(input logit_t d, input logic l);
    int n = 0;
    bus.logit_valid = 1'b1;
    bus.logit_data  = d;
    bus.logit_last  = l;
    while (bus.logit_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", bus.logit_ready, 1);
    @(negedge clk);
    last_beat_cyc   = cyc;
    bus.logit_valid = 1'b0;
    bus.logit_last  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_beat(fb[i], i == n - 1);
  endtask

  task automatic load_normal();
    for (int i = 0; i < 10; i++) fb[i] = norm[i];
  endtask

  task automatic wait_valid(output int rise);
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rise = cyc;
    check("res_valid_wait", bus.res_valid, 1);
  endtask

  // Pops the scoreboard against the presented result and completes the handshake.
  task automatic take_result();
    exp_t e;
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_err++;
      $error("FAIL sb_pop: observed result with %0d expected entries queued", sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("res_class", bus.res_class, e.cls);
      check("res_error", bus.res_error, e.err);
    end
    @(negedge clk);
    exp_img++;
    check("image_count", bus.image_count, exp_img);
    check("post_logit_ready", bus.logit_ready, 1);
    check("post_busy", bus.busy, 0);
    check("post_res_valid", bus.res_valid, 0);
  endtask

  task automatic run_normal();
    int f0;
    int rise;
    f0 = fire_cnt;
    load_normal();
    sb_q.push_back('{err: 1'b0, cls: 4'd3});
    send_frame(10);
    wait_valid(rise);
    check("fire_count", fire_cnt - f0, 1);
    check("fire_cycle", fire_cyc, last_beat_cyc);
    check("done_latency", rise - fire_cyc, AM_LAT + 2);
    take_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    int rise;
    logit_t e7;

    bus.logit_valid = 1'b0;
    bus.logit_data  = '0;
    bus.logit_last  = 1'b0;
    bus.res_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Normal frame, winner at index 3
    run_normal();

    // All-negative frame, winner at index 7, stored sign-correct
    for (int i = 0; i < 10; i++) fb[i] = -1000;
    fb[7] = -5;
    f0 = fire_cnt;
    sb_q.push_back('{err: 1'b0, cls: 4'd7});
    send_frame(10);
    wait_valid(rise);
    e7 = -5;
    check("am_data7", bus.am_data[7], e7);
    check("am_data0", bus.am_data[0], fb[0]);
    check("neg_fire_count", fire_cnt - f0, 1);
    take_result();

    // Short frame -> error, no fire
    for (int i = 0; i < 4; i++) fb[i] = 64'(i * 7);
    f0 = fire_cnt;
    sb_q.push_back('{err: 1'b1, cls: 4'hF});
    send_frame(4);
    wait_valid(rise);
    check("short_busy", bus.busy, 1);
    check("short_logit_ready", bus.logit_ready, 0);
    take_result();
    check("short_no_fire", fire_cnt - f0, 0);

    // Recovery frame, winner at index 2
    for (int i = 0; i < 10; i++) fb[i] = 64'(i + 1);
    fb[2] = 300;
    sb_q.push_back('{err: 1'b0, cls: 4'd2});
    send_frame(10);
    wait_valid(rise);
    take_result();

    // Long frame: beats 11 and 12 drained with ready held high
    for (int i = 0; i < 12; i++) fb[i] = 64'(i * 3);
    f0 = fire_cnt;
    sb_q.push_back('{err: 1'b1, cls: 4'hF});
    for (int i = 0; i < 12; i++) begin
      if (i >= 10) check("drain_ready", bus.logit_ready, 1);
      send_beat(fb[i], i == 11);
    end
    wait_valid(rise);
    take_result();
    check("long_no_fire", fire_cnt - f0, 0);

    // Hung argmax -> timeout error after TIMEOUT cycles in WAIT
    stub_mode = 1'b1;
    load_normal();
    f0 = fire_cnt;
    sb_q.push_back('{err: 1'b1, cls: 4'hF});
    send_frame(10);
    wait_valid(rise);
    check("timeout_fire_count", fire_cnt - f0, 1);
    check("timeout_wait_cycles", rise - (fire_cyc + 1), TIMEOUT);
    take_result();
    stub_mode = 1'b0;

    // Spurious done while idle must not produce a result
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    check("spur_res_valid", bus.res_valid, 0);
    check("spur_busy", bus.busy, 0);
    check("spur_image_count", bus.image_count, exp_img);
    run_normal();

    // Backpressure: result held stable, then reset mid-HOLD
    bus.res_ready = 1'b0;
    load_normal();
    send_frame(10);
    wait_valid(rise);
    for (int k = 0; k < 20; k++) begin
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_class", bus.res_class, 3);
      check("bp_res_error", bus.res_error, 0);
      check("bp_logit_ready", bus.logit_ready, 0);
      @(negedge clk);
    end
    check("bp_image_count", bus.image_count, exp_img);
    rst_n = 1'b0;
    #1;
    check_reset();
    exp_img = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_res_valid", bus.res_valid, 0);
    run_normal();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
